// File: rtl/rr_arb_mux_4.sv
// rr_arb_mux_4 -- four-channel valid/ready arbiter feeding a registered 4:1 mux.
//
// Picks one of four request channels per cycle, captures the chosen word and
// its channel index into a one-deep output register, and presents them on a
// valid/ready output. The output register reloads on the same edge it is
// consumed, so a continuously ready consumer sees one word per cycle.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   in_valid   [3:0] per-channel request
//   in_ready   [3:0] per-channel accept, one-hot or zero
//   d0..d3     [WIDTH-1:0] channel data
//   out_valid  registered word valid
//   out_ready  downstream accept
//   out_data   [WIDTH-1:0] registered selected word
//   out_sel    [1:0] channel that supplied out_data
//
// Configuration macro RR_ARB_FIXED_PRIO_EN:
//   defined   -> fixed priority, channel 0 first (no rotation state)
//   undefined -> round-robin starting after the last granted channel
module rr_arb_mux_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             load;
    logic             xfer;
    logic [1:0]       grant;
    logic [1:0]       base;
    logic [WIDTH-1:0] dmux;

`ifdef RR_ARB_FIXED_PRIO_EN
    // Search begins at base+1, so base=3 yields the order 0,1,2,3.
    assign base = 2'd3;
`else
    logic [1:0] last_grant;
    assign base = last_grant;
`endif

    assign out_valid = (state_q == FULL);
    assign load      = !out_valid || out_ready;
    assign xfer      = load && (|in_valid);

    // First requesting channel after base, wrapping modulo 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign in_ready = xfer ? (4'b0001 << grant) : 4'b0000;

    always_comb begin
        dmux = d0;
        case (grant)
            2'd0: dmux = d0;
            2'd1: dmux = d1;
            2'd2: dmux = d2;
            2'd3: dmux = d3;
            default: dmux = d0;
        endcase
    end

    // A load slot either refills the register or drains it; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load)
            state_d = xfer ? FULL : EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Data, select and rotation pointer move only on a real transfer, so
    // idle cycles do not rotate priority and a drained word keeps its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= 2'd0;
        end else if (xfer) begin
            out_data <= dmux;
            out_sel  <= grant;
        end
    end

`ifndef RR_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 2'd3;
        else if (xfer)
            last_grant <= grant;
    end
`endif

endmodule

// File: tb/tb_rr_arb_mux_4.sv
module tb_rr_arb_mux_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d0, d1, d2, d3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int checks   = 0;
    int failures = 0;

    // Reference state: the output register as a one-deep buffer.
    int m_valid, m_data, m_sel, m_last;
    int m_grant;

    rr_arb_mux_4 #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int data_of(input int c);
        case (c)
            0: return int'(d0);
            1: return int'(d1);
            2: return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    // Channel that should win this cycle, or -1 if none may be accepted.
    function automatic int exp_grant();
        int c;
        if (!(m_valid == 0 || out_ready)) return -1;
        for (int k = 1; k <= 4; k++) begin
`ifdef RR_ARB_FIXED_PRIO_EN
            c = k - 1;
`else
            c = (m_last + k) % 4;
`endif
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check combinational accept, clock, update model, check outputs.
    task automatic cyc();
        int rdy_exp;
        #2;
        m_grant = exp_grant();
        rdy_exp = (m_grant >= 0) ? (1 << m_grant) : 0;
        chk("in_ready", int'(in_ready), rdy_exp);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_last = 3;
        end else if (m_valid == 0 || out_ready) begin
            if (m_grant >= 0) begin
                m_valid = 1; m_data = data_of(m_grant); m_sel = m_grant; m_last = m_grant;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", int'(out_valid), m_valid);
        if (m_valid != 0 || rst) begin
            chk("out_data", int'(out_data), m_data);
            chk("out_sel", int'(out_sel), m_sel);
        end
    endtask

    initial begin
        int saved_last;
        m_valid = 0; m_data = 0; m_sel = 0; m_last = 3; m_grant = -1;
        rst = 1; in_valid = 4'b0; out_ready = 1'b0;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;

        // 1: reset
        cyc(); cyc();
        rst = 0;
        cyc();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_sel", int'(out_sel), 0);

        // 2: all channels busy, consumer always ready -> 0,1,2,3,0,...
        in_valid = 4'b1111; out_ready = 1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        for (int i = 0; i < 8; i++) begin
            cyc();
`ifndef RR_ARB_FIXED_PRIO_EN
            chk("rr_seq_sel", int'(out_sel), i % 4);
            chk("rr_seq_data", int'(out_data), (i % 4) + 1);
`else
            chk("fp_seq_sel", int'(out_sel), 0);
`endif
        end

        // drain
        in_valid = 4'b0000;
        cyc();

        // 3: backpressure hold
        in_valid = 4'b0100; d2 = 4'hA; out_ready = 0;
        cyc();
        in_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b1111;
            cyc();
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), 10);
            chk("stall_sel", int'(out_sel), 2);
        end
        in_valid = 4'b0000; out_ready = 1;
        cyc();
        chk("stall_consumed", int'(out_valid), 0);

        // 4: wrap 3 -> 0
        in_valid = 4'b1000;
        cyc();
        chk("grant3", int'(out_sel), 3);
        in_valid = 4'b1001;
        cyc();
        chk("wrap_to_0", int'(out_sel), 0);

        // 5: reset while FULL and stalled
        in_valid = 4'b0010; out_ready = 0;
        cyc();
        rst = 1;
        cyc();
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_sel", int'(out_sel), 0);
        rst = 0; in_valid = 4'b1111; out_ready = 1;
        cyc();
        chk("post_rst_grant", int'(out_sel), 0);

        // 6: idle while FULL does not rotate priority
        in_valid = 4'b1111;
        cyc();
        saved_last = int'(out_sel);
        in_valid = 4'b0000;
        cyc();
        chk("idle_drop", int'(out_valid), 0);
        cyc();
        in_valid = 4'b1111;
        cyc();
`ifndef RR_ARB_FIXED_PRIO_EN
        chk("idle_no_rotate", int'(out_sel), (saved_last + 1) % 4);
`else
        chk("idle_no_rotate", int'(out_sel), 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            d0 = 4'($urandom()); d1 = 4'($urandom());
            d2 = 4'($urandom()); d3 = 4'($urandom());
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
